spam_lr_classifier: RTL and testbench

//  Downstream inference/scoring stage for the SGD logistic-regression trainer.
//  - On trainer completion, copies the trained Q6.10 weight vector through the trainer's theta read port.
//  - Classifies a stream of test samples with the same Q6.10 arithmetic and Hard-Sigmoid.
//  - Emits per-sample probability/prediction and accumulates correct/wrong counts.

---
 rtl/spam_pkg.sv | 28 ++
 rtl/spam_hard_sigmoid.sv | 27 ++
 rtl/spam_lr_classifier.sv | 148 ++++++++++++++
 tb/tb_spam_lr_classifier.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spam_pkg.sv
// rtl/spam_pkg.sv - shared Q6.10 constants, multiply helper and FSM state type for the spam LR stages
package spam_pkg;

  localparam int NUM_FEATURES_DEF = 32;
  localparam int NUM_TEST_DEF     = 20;

  localparam logic signed [15:0] Q_ONE  = 16'sd1024;
  localparam logic signed [15:0] Q_HALF = 16'sd512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY,
    S_LOAD,
    S_WAIT_LBL,
    S_DOT,
    S_CLASS,
    S_DONE
  } state_t;

  // Floor-shifted product, wrapped back to 16 bits.
  function automatic logic signed [15:0] q6_10_mul(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
    logic signed [31:0] prod;
    prod = 32'(a) * 32'(b);
    return 16'(prod >>> 10);
  endfunction

endpackage

// File: rtl/spam_hard_sigmoid.sv
// rtl/spam_hard_sigmoid.sv - combinational Hard-Sigmoid: Q6.10 score to probability and class
module spam_hard_sigmoid
  import spam_pkg::*;
(
  input  logic signed [15:0] acc,
  output logic [15:0]        prob,
  output logic               pred
);

  logic signed [15:0] quarter;
  logic signed [15:0] sum;

  // The quarter-slope line cannot overflow 16 bits, so the clamp sees the true value.
  always_comb begin
    quarter = acc >>> 2;
    sum     = Q_HALF + quarter;
    if (sum < 16'sd0) begin
      prob = 16'd0;
    end else if (sum > Q_ONE) begin
      prob = Q_ONE;
    end else begin
      prob = sum;
    end
    pred = (quarter > 16'sd0);
  end

endmodule

// File: rtl/spam_lr_classifier.sv
// rtl/spam_lr_classifier.sv - copies trained weights, scores a test stream and tallies accuracy
module spam_lr_classifier
  import spam_pkg::*;
#(
  parameter int NUM_FEATURES = NUM_FEATURES_DEF,
  parameter int NUM_TEST     = NUM_TEST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        train_done,
  output logic [5:0]  theta_rd_idx,
  input  logic [15:0] theta_rd_data,
  input  logic [15:0] feat_in,
  input  logic        feat_valid,
  output logic        feat_ready,
  input  logic [7:0]  label_in,
  input  logic        label_valid,
  output logic        label_ready,
  output logic        pred_valid,
  output logic [15:0] pred_prob,
  output logic        pred_label,
  output logic [7:0]  num_correct,
  output logic [7:0]  num_wrong,
  output logic        test_done
);

  localparam int         IW          = $clog2(NUM_FEATURES);
  localparam logic [5:0] LAST_IDX    = 6'(NUM_FEATURES - 1);
  localparam logic [7:0] LAST_SAMPLE = 8'(NUM_TEST - 1);

  state_t             state;
  logic               train_done_q;
  logic               start_run;
  logic               label_q;
  logic [5:0]         cnt;
  logic [IW-1:0]      idx;
  logic [7:0]         sample_cnt;
  logic signed [15:0] acc;
  logic signed [15:0] wbuf [NUM_FEATURES];
  logic signed [15:0] fbuf [NUM_FEATURES];
  logic [15:0]        sig_prob;
  logic               sig_pred;

  assign start_run    = train_done & ~train_done_q;
  assign idx          = cnt[IW-1:0];
  assign theta_rd_idx = (state == S_COPY) ? cnt : 6'd0;
  assign feat_ready   = (state == S_LOAD);
  assign label_ready  = (state == S_WAIT_LBL);

  spam_hard_sigmoid u_sigmoid (
    .acc  (acc),
    .prob (sig_prob),
    .pred (sig_pred)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      train_done_q <= 1'b0;
      label_q      <= 1'b0;
      cnt          <= 6'd0;
      sample_cnt   <= 8'd0;
      acc          <= 16'sd0;
      pred_valid   <= 1'b0;
      pred_prob    <= 16'd0;
      pred_label   <= 1'b0;
      num_correct  <= 8'd0;
      num_wrong    <= 8'd0;
      test_done    <= 1'b0;
      for (int i = 0; i < NUM_FEATURES; i++) begin
        wbuf[i] <= 16'sd0;
        fbuf[i] <= 16'sd0;
      end
    end else begin
      train_done_q <= train_done;
      pred_valid   <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_run) begin
            state       <= S_COPY;
            cnt         <= 6'd0;
            sample_cnt  <= 8'd0;
            num_correct <= 8'd0;
            num_wrong   <= 8'd0;
            test_done   <= 1'b0;
          end
        end
        S_COPY: begin
          wbuf[idx] <= theta_rd_data;
          if (cnt == LAST_IDX) begin
            cnt   <= 6'd0;
            state <= S_LOAD;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_LOAD: begin
          if (feat_valid) begin
            fbuf[idx] <= feat_in;
            if (cnt == LAST_IDX) begin
              cnt   <= 6'd0;
              state <= S_WAIT_LBL;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        S_WAIT_LBL: begin
          if (label_valid) begin
            label_q <= |label_in;
            acc     <= 16'sd0;
            cnt     <= 6'd0;
            state   <= S_DOT;
          end
        end
        S_DOT: begin
          acc <= acc + q6_10_mul(wbuf[idx], fbuf[idx]);
          if (cnt == LAST_IDX) begin
            cnt   <= 6'd0;
            state <= S_CLASS;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_CLASS: begin
          pred_valid <= 1'b1;
          pred_prob  <= sig_prob;
          pred_label <= sig_pred;
          if (sig_pred == label_q) begin
            num_correct <= num_correct + 8'd1;
          end else begin
            num_wrong <= num_wrong + 8'd1;
          end
          if (sample_cnt == LAST_SAMPLE) begin
            test_done <= 1'b1;
            state     <= S_DONE;
          end else begin
            sample_cnt <= sample_cnt + 8'd1;
            cnt        <= 6'd0;
            state      <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spam_lr_classifier.sv
// tb/tb_spam_lr_classifier.sv - directed and randomized bench for spam_lr_classifier
module tb_spam_lr_classifier;

  localparam int NF = 32;
  localparam int NT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        train_done = 1'b0;
  logic [5:0]  theta_rd_idx;
  logic [15:0] theta_rd_data;
  logic [15:0] feat_in = 16'd0;
  logic        feat_valid = 1'b0;
  logic        feat_ready;
  logic [7:0]  label_in = 8'd0;
  logic        label_valid = 1'b0;
  logic        label_ready;
  logic        pred_valid;
  logic [15:0] pred_prob;
  logic        pred_label;
  logic [7:0]  num_correct;
  logic [7:0]  num_wrong;
  logic        test_done;

  logic signed [15:0] tw [NF];
  logic signed [15:0] tf [NF];
  int tests = 0;
  int fails = 0;
  int exp_correct = 0;
  int exp_wrong = 0;
  int exp_samples = 0;
  int hs_to = 0;

  always #5 clk = ~clk;

  assign theta_rd_data = tw[theta_rd_idx[4:0]];

  spam_lr_classifier #(.NUM_FEATURES(NF), .NUM_TEST(NT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .train_done    (train_done),
    .theta_rd_idx  (theta_rd_idx),
    .theta_rd_data (theta_rd_data),
    .feat_in       (feat_in),
    .feat_valid    (feat_valid),
    .feat_ready    (feat_ready),
    .label_in      (label_in),
    .label_valid   (label_valid),
    .label_ready   (label_ready),
    .pred_valid    (pred_valid),
    .pred_prob     (pred_prob),
    .pred_label    (pred_label),
    .num_correct   (num_correct),
    .num_wrong     (num_wrong),
    .test_done     (test_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference score: exact dot product of floored products, reduced mod 2^16 once at the end.
  function automatic int model_prob();
    longint s = 0;
    int a;
    int p;
    for (int i = 0; i < NF; i++) s += (longint'(tw[i]) * longint'(tf[i])) >>> 10;
    a = int'(shortint'(s));
    p = 512 + (a >>> 2);
    if (p < 0) p = 0;
    if (p > 1024) p = 1024;
    return p;
  endfunction

  task automatic start_chk();
    int bad = 0;
    train_done = 1'b1;
    @(negedge clk);
    exp_correct = 0;
    exp_wrong   = 0;
    exp_samples = 0;
    chk("start_num_correct", num_correct, 0);
    chk("start_num_wrong", num_wrong, 0);
    chk("start_test_done", test_done, 0);
    for (int i = 0; i < NF; i++) begin
      if (theta_rd_idx !== 6'(i)) bad++;
      @(negedge clk);
    end
    chk("copy_idx_sequence_errors", bad, 0);
    chk("copy_len_then_load", feat_ready, 1);
    chk("idx_zero_after_copy", theta_rd_idx, 0);
    train_done = 1'b0;
  endtask

  task automatic send_feats();
    int t;
    for (int i = 0; i < NF; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        feat_valid = 1'b0;
        @(negedge clk);
      end
      feat_valid = 1'b1;
      feat_in    = tf[i];
      t = 0;
      while (!feat_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) hs_to++;
      @(negedge clk);
    end
    feat_valid = 1'b0;
  endtask

  task automatic send_label(input bit lbl);
    int t = 0;
    label_in    = lbl ? 8'($urandom_range(1, 255)) : 8'd0;
    label_valid = 1'b1;
    while (!label_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) hs_to++;
    @(negedge clk);
    label_valid = 1'b0;
    label_in    = 8'h5a;
  endtask

  task automatic finish_pred(input bit lbl, input bit junk);
    int lat = 1;
    int ep;
    bit epd;
    while (!pred_valid && lat < 200) begin
      feat_valid = junk && (lat < 20);
      feat_in    = 16'($urandom);
      @(negedge clk);
      lat++;
    end
    feat_valid = 1'b0;
    ep  = model_prob();
    epd = (ep > 512);
    if (epd == lbl) exp_correct++;
    else exp_wrong++;
    exp_samples++;
    chk("latency", lat, NF + 2);
    chk("pred_prob", pred_prob, ep);
    chk("pred_label", pred_label, epd);
    chk("num_correct", num_correct, exp_correct);
    chk("num_wrong", num_wrong, exp_wrong);
    chk("test_done", test_done, exp_samples == NT);
    chk("handshake_timeouts", hs_to, 0);
    @(negedge clk);
    chk("pred_valid_pulse", pred_valid, 0);
  endtask

  task automatic run_sample(input bit lbl, input bit junk);
    send_feats();
    send_label(lbl);
    finish_pred(lbl, junk);
  endtask

  task automatic clear_feats();
    for (int i = 0; i < NF; i++) tf[i] = 16'sd0;
  endtask

  task automatic rand_feats();
    for (int i = 0; i < NF; i++) tf[i] = 16'(int'($urandom_range(0, 4095)) - 2048);
  endtask

  initial begin
    for (int i = 0; i < NF; i++) tw[i] = 16'sd0;
    clear_feats();
    repeat (2) @(negedge clk);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_prob", pred_prob, 0);
    chk("rst_num_correct", num_correct, 0);
    chk("rst_num_wrong", num_wrong, 0);
    chk("rst_test_done", test_done, 0);
    chk("rst_theta_idx", theta_rd_idx, 0);
    chk("rst_feat_ready", feat_ready, 0);
    chk("rst_label_ready", label_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero weights: every score is exactly one half.
    start_chk();
    for (int s = 0; s < NT; s++) begin
      rand_feats();
      run_sample(s == 1, 1'b0);
      chk("zero_w_prob", pred_prob, 512);
    end
    repeat (5) @(negedge clk);
    chk("done_held", test_done, 1);
    chk("done_correct_held", num_correct, 2);

    tw[0] = 16'sd1024;
    tw[1] = 16'sd16384;
    tw[2] = 16'sd16384;
    start_chk();
    clear_feats();
    tf[0] = 16'sd4096;
    run_sample(1'b1, 1'b0);
    chk("clamp_high_prob", pred_prob, 1024);
    train_done = 1'b1;
    repeat (2) @(negedge clk);
    train_done = 1'b0;
    @(negedge clk);
    chk("start_ignored_ready", feat_ready, 1);
    chk("start_ignored_count", num_correct, 1);
    tf[0] = -16'sd1024;
    run_sample(1'b1, 1'b1);
    chk("neg_prob", pred_prob, 256);
    chk("neg_wrong", num_wrong, 1);
    tf[0] = 16'sd4;
    run_sample(1'b0, 1'b1);
    chk("thresh_513", pred_prob, 513);
    chk("thresh_513_pred", pred_label, 1);

    start_chk();
    tf[0] = 16'sd3;
    run_sample(1'b0, 1'b0);
    chk("thresh_512", pred_prob, 512);
    chk("thresh_512_pred", pred_label, 0);
    clear_feats();
    tf[1] = 16'sd1536;
    tf[2] = 16'sd1536;
    run_sample(1'b0, 1'b0);
    chk("wrap_acc_prob", pred_prob, 0);
    tf[1] = 16'sd8192;
    tf[2] = 16'sd8192;
    run_sample(1'b1, 1'b0);
    chk("wrap_mul_prob", pred_prob, 512);

    for (int i = 0; i < NF; i++) tw[i] = 16'(int'($urandom_range(0, 2047)) - 1024);
    start_chk();
    for (int s = 0; s < NT; s++) begin
      rand_feats();
      run_sample(1'($urandom_range(0, 1)), 1'b1);
    end

    // Abort a sample mid dot product with reset.
    start_chk();
    rand_feats();
    run_sample(1'b1, 1'b0);
    rand_feats();
    send_feats();
    send_label(1'b1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_pred_valid", pred_valid, 0);
    chk("abort_pred_prob", pred_prob, 0);
    chk("abort_pred_label", pred_label, 0);
    chk("abort_num_correct", num_correct, 0);
    chk("abort_num_wrong", num_wrong, 0);
    chk("abort_test_done", test_done, 0);
    chk("abort_theta_idx", theta_rd_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int pv = 0;
      repeat (40) begin
        @(negedge clk);
        if (pred_valid) pv++;
      end
      chk("abort_no_pred", pv, 0);
      chk("abort_idle_ready", feat_ready, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
